mac_acc_12: RTL and testbench

- Accumulator stage directly downstream of the 12-bit integer multiplier in the float_arith/int datapath.
- Consumes the multiplier's 12-bit unsigned product stream and adds NUM_TERMS products plus a per-group bias.
- Emits one saturated 12-bit dot-product result per group with a single-cycle valid pulse, for neuron/kernel evaluation.

---
 rtl/mac_acc_12.sv | 109 ++++++++++
 tb/tb_mac_acc_12.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_12.sv
// mac_acc_12: accumulates NUM_TERMS unsigned 12-bit products plus a per-group
// bias and emits one saturated 12-bit result per group with a one-cycle pulse.
module mac_acc_12 #(
    parameter int NUM_TERMS = 9,
    parameter int ACC_W     = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [11:0] bias_i,
    input  logic        data_valid_i,
    input  logic [11:0] data_i,
    output logic [11:0] sum_o,
    output logic        sum_valid_o,
    output logic        busy_o
);

    // A group of one term is meaningless and the term counter is 8 bits wide.
    if (NUM_TERMS < 2 || NUM_TERMS > 255) begin : g_bad_num_terms
        $error("mac_acc_12: NUM_TERMS must be in 2..255");
    end

    // Accumulator must hold 4095*(NUM_TERMS+1) without wrapping.
    if (ACC_W < 13 + $clog2(NUM_TERMS)) begin : g_bad_acc_w
        $error("mac_acc_12: ACC_W too narrow for NUM_TERMS");
    end

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    localparam logic [7:0]       LAST_IDX = 8'(NUM_TERMS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'(12'hFFF);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_count;
    logic [11:0]      r_sum;
    logic             r_sum_valid;

    state_t           w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       w_count_nxt;
    logic [11:0]      w_sum_nxt;
    logic             w_sum_valid_nxt;
    logic [ACC_W-1:0] w_acc_add;
    logic [ACC_W-1:0] w_first;

    assign w_acc_add = r_acc + ACC_W'(data_i);
    assign w_first   = ACC_W'(bias_i) + ACC_W'(data_i);

    // State, accumulator and output registers; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_valid <= w_sum_valid_nxt;
        end
    end

    // Next-state: clear aborts the group and drops any term offered with it.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_count_nxt     = r_count;
        w_sum_nxt       = r_sum;
        w_sum_valid_nxt = 1'b0;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
        end else if (data_valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    w_acc_nxt   = w_first;
                    w_count_nxt = 8'd1;
                    w_state_nxt = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (r_count == LAST_IDX) begin
                        w_sum_nxt       = (w_acc_add > SAT_MAX) ? 12'hFFF : w_acc_add[11:0];
                        w_sum_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_count_nxt     = '0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_acc_nxt   = w_acc_add;
                        w_count_nxt = r_count + 8'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign busy_o      = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_mac_acc_12.sv
// Bench for mac_acc_12 (NUM_TERMS=4): directed groups plus random traffic,
// checked every cycle against a queue-based group model.
module tb_mac_acc_12;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [11:0] bias = '0;
    logic        dv = 1'b0;
    logic [11:0] data = '0;
    logic [11:0] sum_o;
    logic        sum_valid_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    // Model state
    int  terms_q[$];
    int  m_bias = 0;
    int  exp_sum = 0;
    bit  exp_valid = 1'b0;
    bit  exp_busy = 1'b0;
    bit  m_ready = 1'b0;

    // Observed pulses
    int  pulses = 0;
    int  last_sum = 0;

    mac_acc_12 #(.NUM_TERMS(N), .ACC_W(20)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clr),
        .bias_i      (bias),
        .data_valid_i(dv),
        .data_i      (data),
        .sum_o       (sum_o),
        .sum_valid_o (sum_valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Group model: collect accepted terms; a full group yields bias+sum, saturated.
    always @(posedge clk) begin
        int total;
        exp_valid = 1'b0;
        if (rst) begin
            terms_q.delete();
            exp_sum = 0;
            m_ready = 1'b1;
        end else if (clr) begin
            terms_q.delete();
        end else if (dv) begin
            if (terms_q.size() == 0) m_bias = int'(bias);
            terms_q.push_back(int'(data));
            if (terms_q.size() == N) begin
                total = m_bias;
                foreach (terms_q[k]) total += terms_q[k];
                exp_sum = (total > 4095) ? 4095 : total;
                exp_valid = 1'b1;
                terms_q.delete();
            end
        end
        exp_busy = (terms_q.size() > 0);
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("sum_valid", int'(sum_valid_o), int'(exp_valid));
            chk("sum", int'(sum_o), exp_sum);
            chk("busy", int'(busy_o), int'(exp_busy));
            if (sum_valid_o) begin
                pulses++;
                last_sum = int'(sum_o);
            end
        end
    end

    task automatic cyc(input bit v, input logic [11:0] d, input logic [11:0] b,
                       input bit c, input bit r);
        dv = v; data = d; bias = b; clr = c; rst = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    endtask

    initial begin
        int p0;
        logic [11:0] t1_terms [4];
        t1_terms[0] = 12'h010; t1_terms[1] = 12'h020;
        t1_terms[2] = 12'h030; t1_terms[3] = 12'h040;

        cyc(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        cyc(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        chk("reset_sum", int'(sum_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        idle(1);

        // T1: consecutive terms with bias
        p0 = pulses;
        for (int i = 0; i < 4; i++) cyc(1'b1, t1_terms[i], 12'h010, 1'b0, 1'b0);
        chk("t1_model", exp_sum, 'h0B0);
        chk("t1_sum", last_sum, 'h0B0);
        chk("t1_pulses", pulses - p0, 1);
        idle(2);
        chk("t1_busy_after", int'(busy_o), 0);

        // T2: saturation
        p0 = pulses;
        for (int i = 0; i < 4; i++) cyc(1'b1, 12'hFF0, 12'h000, 1'b0, 1'b0);
        idle(3);
        chk("t2_sum", last_sum, 'hFFF);
        chk("t2_pulses", pulses - p0, 1);

        // T3: gaps between terms
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, t1_terms[i], 12'h010, 1'b0, 1'b0);
            if (i < 3) begin
                idle(3);
                chk("t3_busy_gap", int'(busy_o), 1);
            end
        end
        chk("t3_sum", last_sum, 'h0B0);
        chk("t3_pulses", pulses - p0, 1);
        idle(2);

        // T4: sustained input, back-to-back groups
        p0 = pulses;
        for (int i = 0; i < 12; i++) cyc(1'b1, 12'h010, 12'h000, 1'b0, 1'b0);
        idle(1);
        chk("t4_sum", last_sum, 'h040);
        chk("t4_pulses", pulses - p0, 3);

        // T5: clear drops partial group and the term offered with it
        p0 = pulses;
        cyc(1'b1, 12'h010, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h010, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h010, 12'h000, 1'b1, 1'b0);
        chk("t5_busy_clr", int'(busy_o), 0);
        chk("t5_sum_held", int'(sum_o), 'h040);
        for (int i = 0; i < 4; i++) cyc(1'b1, 12'h010, 12'h000, 1'b0, 1'b0);
        idle(1);
        chk("t5_sum", last_sum, 'h040);
        chk("t5_pulses", pulses - p0, 1);

        // T6: reset mid-group
        p0 = pulses;
        cyc(1'b1, 12'h020, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 12'h020, 12'h000, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        chk("t6_rst_sum", int'(sum_o), 0);
        chk("t6_rst_busy", int'(busy_o), 0);
        chk("t6_rst_valid", int'(sum_valid_o), 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 12'h020, 12'h000, 1'b0, 1'b0);
        idle(1);
        chk("t6_sum", last_sum, 'h080);
        chk("t6_pulses", pulses - p0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                12'($urandom_range(0, 4095)),
                12'($urandom_range(0, 4095)),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 99) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
